// File: rtl/verlet_node_p.sv
// verlet_node_p: one cloth particle (pos + prev pos) with verlet/fix/mouse/nop
// commands. Ports: clk, reset, start/cmd/pin_en/fix_*/mouse_* in, out_*/busy/done out.
module verlet_node_p #(
  parameter int WIDTH      = 32,
  parameter int INIT_X     = 200,
  parameter int INIT_Y     = 10,
  parameter int GRAVITY    = 1,
  parameter int DAMP_SHIFT = 0,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int GRAB_R     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic             pin_en,
  input  logic [WIDTH-1:0] fix_x,
  input  logic [WIDTH-1:0] fix_y,
  input  logic [WIDTH-1:0] mouse_x,
  input  logic [WIDTH-1:0] mouse_y,
  input  logic             mouse_down,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             busy,
  output logic             done
);

  localparam int EW = WIDTH + 2;
  typedef logic signed [EW-1:0] ew_t;

  localparam ew_t GRAV = ew_t'(GRAVITY);
  localparam ew_t XMAX = ew_t'(X_MAX);
  localparam ew_t YMAX = ew_t'(Y_MAX);
  localparam ew_t GRAB = ew_t'(GRAB_R);

  localparam logic [1:0] CMD_VERLET = 2'b00;
  localparam logic [1:0] CMD_FIX    = 2'b01;
  localparam logic [1:0] CMD_MOUSE  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       cmd_q;
  logic             pin_q;
  logic             md_q;
  logic [WIDTH-1:0] fx_q, fy_q;
  logic [WIDTH-1:0] mx_q, my_q;
  logic [WIDTH-1:0] x_q, y_q, px_q, py_q;
  logic [WIDTH-1:0] cx_q, cy_q, cpx_q, cpy_q;
  logic [WIDTH-1:0] cx_d, cy_d, cpx_d, cpy_d;
  logic             done_q;

  function automatic ew_t sx(input logic [WIDTH-1:0] a);
    return {{2{a[WIDTH-1]}}, a};
  endfunction

  function automatic logic oob(input ew_t v, input ew_t hi);
    return v[EW-1] || (v > hi);
  endfunction

  function automatic logic [WIDTH-1:0] clampv(
    input ew_t v,
    input ew_t hi
  );
    if (v[EW-1]) return '0;
    if (v > hi) return hi[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  ew_t vx, vy, nx, ny;
  ew_t mxe, mye, dx, dy, adx, ady;
  logic grab;

  always_comb begin
    vx  = sx(x_q) - sx(px_q);
    vy  = sy_pos();
    // Damping discards v - (v >>> DAMP_SHIFT); what survives is v >>> DAMP_SHIFT.
    nx  = sx(x_q) + (vx >>> DAMP_SHIFT);
    ny  = sx(y_q) + (vy >>> DAMP_SHIFT) + GRAV;
    mxe = sx(mx_q);
    mye = sx(my_q);
    dx  = mxe - sx(x_q);
    dy  = mye - sx(y_q);
    adx = dx[EW-1] ? -dx : dx;
    ady = dy[EW-1] ? -dy : dy;
    grab = md_q && !pin_q && (adx <= GRAB) && (ady <= GRAB);

    cx_d  = x_q;
    cy_d  = y_q;
    cpx_d = px_q;
    cpy_d = py_q;
    unique case (cmd_q)
      CMD_VERLET: begin
        if (pin_q) begin
          cpx_d = x_q;
          cpy_d = y_q;
        end else begin
          cx_d  = clampv(nx, XMAX);
          cy_d  = clampv(ny, YMAX);
          // A clamped axis gets prev = pos so its velocity dies.
          cpx_d = oob(nx, XMAX) ? cx_d : x_q;
          cpy_d = oob(ny, YMAX) ? cy_d : y_q;
        end
      end
      CMD_FIX: begin
        if (pin_q) begin
          cx_d  = fx_q;
          cy_d  = fy_q;
          cpx_d = fx_q;
          cpy_d = fy_q;
        end
      end
      CMD_MOUSE: begin
        if (grab) begin
          cx_d  = clampv(mxe, XMAX);
          cy_d  = clampv(mye, YMAX);
          cpx_d = cx_d;
          cpy_d = cy_d;
        end
      end
      default: ;
    endcase
  end

  function automatic ew_t sy_pos();
    return sx(y_q) - sx(py_q);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= '0;
      pin_q  <= 1'b0;
      md_q   <= 1'b0;
      fx_q   <= '0;
      fy_q   <= '0;
      mx_q   <= '0;
      my_q   <= '0;
      x_q    <= WIDTH'(INIT_X);
      y_q    <= WIDTH'(INIT_Y);
      px_q   <= WIDTH'(INIT_X);
      py_q   <= WIDTH'(INIT_Y);
      cx_q   <= '0;
      cy_q   <= '0;
      cpx_q  <= '0;
      cpy_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_WB);
      if (state_q == S_IDLE && start) begin
        cmd_q <= cmd;
        pin_q <= pin_en;
        md_q  <= mouse_down;
        fx_q  <= fix_x;
        fy_q  <= fix_y;
        mx_q  <= mouse_x;
        my_q  <= mouse_y;
      end
      if (state_q == S_EXEC) begin
        cx_q  <= cx_d;
        cy_q  <= cy_d;
        cpx_q <= cpx_d;
        cpy_q <= cpy_d;
      end
      if (state_q == S_WB) begin
        x_q  <= cx_q;
        y_q  <= cy_q;
        px_q <= cpx_q;
        py_q <= cpy_q;
      end
    end
  end

  assign out_x = x_q;
  assign out_y = y_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_verlet_node_p.sv
// tb_verlet_node_p: scoreboard bench for verlet_node_p with default,
// Y_MAX=12 and DAMP_SHIFT=1 instances driven in lockstep.
module tb_verlet_node_p;

  localparam int W = 32;
  typedef logic [2*W-1:0] pos_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   cmd = 2'b11;
  logic         pin_en = 1'b0;
  logic         mouse_down = 1'b0;
  logic [W-1:0] fix_x = '0, fix_y = '0;
  logic [W-1:0] mouse_x = '0, mouse_y = '0;

  logic [W-1:0] x0, y0, x1, y1, x2, y2;
  logic         busy0, busy1, busy2;
  logic         done0, done1, done2;

  int   n_chk = 0;
  int   n_fail = 0;
  pos_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  verlet_node_p u0 (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .pin_en(pin_en), .fix_x(fix_x), .fix_y(fix_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_down(mouse_down), .out_x(x0), .out_y(y0),
    .busy(busy0), .done(done0)
  );

  verlet_node_p #(.Y_MAX(12)) u1 (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .pin_en(pin_en), .fix_x(fix_x), .fix_y(fix_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_down(mouse_down), .out_x(x1), .out_y(y1),
    .busy(busy1), .done(done1)
  );

  verlet_node_p #(.DAMP_SHIFT(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .pin_en(pin_en), .fix_x(fix_x), .fix_y(fix_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_down(mouse_down), .out_x(x2), .out_y(y2),
    .busy(busy2), .done(done2)
  );

  function automatic pos_t P(input int x, input int y);
    return {W'(x), W'(y)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Issues one command from a negedge; returns at the negedge where done is seen.
  task automatic run(
    input  logic [1:0] c,
    input  logic       p,
    input  int         fx,
    input  int         fy,
    input  int         mx,
    input  int         my,
    input  logic       md,
    output int         lat,
    output bit         to
  );
    cmd        = c;
    pin_en     = p;
    fix_x      = W'(fx);
    fix_y      = W'(fy);
    mouse_x    = W'(mx);
    mouse_y    = W'(my);
    mouse_down = md;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done0 !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    to = (done0 !== 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    cmd   = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    n_chk++;
    if ({x0, y0} !== P(200, 10)) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) want (200,10)",
               $signed(x0), $signed(y0));
    end
    n_chk++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0",
               busy0, done0);
    end
    @(negedge clk);
    n_chk++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_txn: got busy=%b want 0", busy0);
    end
  endtask

  task automatic test_free_fall_clamp();
    int   e0y[3] = '{11, 13, 16};
    int   e1y[3] = '{11, 12, 12};
    int   e2y[3] = '{11, 12, 13};
    int   lat;
    bit   to;
    pos_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(P(200, e0y[i]));
      q1.push_back(P(200, e1y[i]));
      q2.push_back(P(200, e2y[i]));
      run(2'b00, 1'b0, 0, 0, 0, 0, 1'b0, lat, to);
      n_chk++;
      if (to || lat != 2) begin
        n_fail++;
        $display("FAIL ff_lat%0d: got %0d want 2", i, lat);
      end
      e = q0.pop_front();
      n_chk++;
      if ({x0, y0} !== e) begin
        n_fail++;
        $display("FAIL ff_pos%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(x0), $signed(y0),
                 $signed(e[2*W-1:W]), $signed(e[W-1:0]));
      end
      e = q1.pop_front();
      n_chk++;
      if ({x1, y1} !== e) begin
        n_fail++;
        $display("FAIL clamp_pos%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(x1), $signed(y1),
                 $signed(e[2*W-1:W]), $signed(e[W-1:0]));
      end
      e = q2.pop_front();
      n_chk++;
      if ({x2, y2} !== e) begin
        n_fail++;
        $display("FAIL damp_pos%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(x2), $signed(y2),
                 $signed(e[2*W-1:W]), $signed(e[W-1:0]));
      end
    end
  endtask

  task automatic test_pin();
    logic [1:0] c[3]  = '{2'b01, 2'b00, 2'b00};
    logic       p[3]  = '{1'b1, 1'b1, 1'b0};
    int         ey[3] = '{50, 50, 51};
    int   lat;
    bit   to;
    pos_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(P(300, ey[i]));
      run(c[i], p[i], 300, 50, 0, 0, 1'b0, lat, to);
      n_chk++;
      if (to || lat != 2 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL pin_hs%0d: got lat=%0d busy=%b want 2 0",
                 i, lat, busy0);
      end
      e = q0.pop_front();
      n_chk++;
      if ({x0, y0} !== e) begin
        n_fail++;
        $display("FAIL pin_pos%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(x0), $signed(y0),
                 $signed(e[2*W-1:W]), $signed(e[W-1:0]));
      end
    end
  endtask

  task automatic test_mouse();
    int   mx[5] = '{205, 220, 210, 213, 213};
    int   my[5] = '{15, 15, 18, 23, 23};
    logic md[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic pn[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   ex[5] = '{205, 205, 205, 205, 213};
    int   ey[5] = '{15, 15, 15, 15, 23};
    int   lat;
    bit   to;
    pos_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q0.push_back(P(ex[i], ey[i]));
      run(2'b10, pn[i], 0, 0, mx[i], my[i], md[i], lat, to);
      n_chk++;
      if (to || lat != 2) begin
        n_fail++;
        $display("FAIL mouse_lat%0d: got %0d want 2", i, lat);
      end
      e = q0.pop_front();
      n_chk++;
      if ({x0, y0} !== e) begin
        n_fail++;
        $display("FAIL mouse_pos%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(x0), $signed(y0),
                 $signed(e[2*W-1:W]), $signed(e[W-1:0]));
      end
    end
  endtask

  task automatic test_nop();
    int   lat;
    bit   to;
    pos_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(P(200, 10));
      run(2'b11, 1'(i), 300, 50, 200, 10, 1'b1, lat, to);
      n_chk++;
      if (to || lat != 2) begin
        n_fail++;
        $display("FAIL nop_lat%0d: got %0d want 2", i, lat);
      end
      e = q0.pop_front();
      n_chk++;
      if ({x0, y0} !== e) begin
        n_fail++;
        $display("FAIL nop_pos%0d: got (%0d,%0d) want (200,10)", i,
                 $signed(x0), $signed(y0));
      end
    end
  endtask

  task automatic test_ignore_busy();
    int   nd = 0;
    pos_t e;
    do_reset();
    q0.push_back(P(200, 11));
    cmd        = 2'b00;
    pin_en     = 1'b0;
    mouse_down = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_busy_exec: got %b want 1", busy0);
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_busy_wb: got busy=%b done=%b want 1 0",
               busy0, done0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        nd++;
        if (nd == 1) begin
          e = q0.pop_front();
          n_chk++;
          if ({x0, y0} !== e) begin
            n_fail++;
            $display("FAIL ign_pos: got (%0d,%0d) want (200,11)",
                     $signed(x0), $signed(y0));
          end
        end
      end
    end
    n_chk++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL ign_done_count: got %0d want 1", nd);
    end
    n_chk++;
    if ({x0, y0} !== P(200, 11) || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_final: got (%0d,%0d) busy=%b want (200,11) 0",
               $signed(x0), $signed(y0), busy0);
    end
  endtask

  task automatic test_abort();
    int nd = 0;
    do_reset();
    cmd    = 2'b00;
    pin_en = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 0", busy0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d pulses want 0", nd);
    end
    n_chk++;
    if ({x0, y0} !== P(200, 10)) begin
      n_fail++;
      $display("FAIL abort_pos: got (%0d,%0d) want (200,10)",
               $signed(x0), $signed(y0));
    end
  endtask

  initial begin
    test_reset();
    test_free_fall_clamp();
    test_pin();
    test_mouse();
    test_nop();
    test_ignore_busy();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/verlet_node_p.md
Name: verlet_node_p

Overview:
- Parametrised successor to the single cloth-simulation node.
- Holds one particle's position and previous position, in signed integer pixel coordinates.
- On command it performs one of four operations, each in a fixed two-cycle transaction with a busy/done handshake:
  - a damped Verlet step with gravity and box clamping;
  - a fix (pin) constraint;
  - a mouse-grab move;
  - a no-op.
- Instantiated once per cloth node under the simulation sequencer, which issues commands and waits for done.

Parameters:
- WIDTH, 32, coordinate width (signed two's complement).
- INIT_X, 200, reset x position.
- INIT_Y, 10, reset y position.
- GRAVITY, 1, added to y displacement each Verlet step.
- DAMP_SHIFT, 0, velocity damping: v - (v>>>DAMP_SHIFT); 0 disables damping.
- X_MAX, 639, upper x bound (lower bound 0).
- Y_MAX, 479, upper y bound (lower bound 0).
- GRAB_R, 8, mouse grab half-width (Chebyshev distance).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, command strobe; accepted only in IDLE.
- cmd, input, 2, 00 verlet, 01 fix, 10 mouse, 11 nop; sampled with start.
- pin_en, input, 1, node is pinned; sampled with start.
- fix_x, input, WIDTH, pin x target; sampled with start.
- fix_y, input, WIDTH, pin y target; sampled with start.
- mouse_x, input, WIDTH, cursor x; sampled with start.
- mouse_y, input, WIDTH, cursor y; sampled with start.
- mouse_down, input, 1, button held; sampled with start.
- out_x, output, WIDTH, current x position (registered).
- out_y, output, WIDTH, current y position (registered).
- busy, output, 1, transaction in progress.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- One clock (clk). reset is synchronous and active-high and overrides everything.
- Reset values:
  - out_x = prev_x = INIT_X; out_y = prev_y = INIT_Y.
  - busy = 0, done = 0, state = IDLE.
- Reset mid-transaction aborts it: no done pulse, position returns to INIT.
- States and transitions:
  - IDLE -> EXEC when start=1. Latch cmd, pin_en, fix, mouse and mouse_down inputs.
  - EXEC -> WB unconditionally. Compute candidate position into internal regs.
  - WB -> IDLE. Write out/prev; done=1 in the cycle after this edge.
- Timing: start at edge k gives busy=1 after k and k+1, new out_x/out_y and done=1 after k+2, busy=0 after k+2.
  - done is high for exactly one cycle.
  - A new start may be accepted in the same cycle that done is high.
- start while busy is ignored. It is not queued.
- Verlet (cmd 00):
  - If pin_en: out unchanged, prev <= out.
  - Else, with vx = x - px and vy = y - py:
    - nx = x + damp(vx); ny = y + damp(vy) + GRAVITY.
    - prev <= old x/y.
- Arithmetic: evaluate in WIDTH+2 bits signed, then clamp each axis to [0, X_MAX] / [0, Y_MAX]. If an axis clamps, prev on that axis <= the clamped value, which zeroes velocity on that axis.
- Fix (cmd 01):
  - If pin_en: out <= fix, prev <= fix.
  - Else no change.
  - No clamping is applied.
- Mouse (cmd 10):
  - If mouse_down, !pin_en, |mouse_x - x| <= GRAB_R and |mouse_y - y| <= GRAB_R: out <= mouse, prev <= mouse, clamped to bounds.
  - Else no change.
  - pin_en has priority over mouse.
- Nop (cmd 11): position unchanged; full handshake still runs and done still pulses.
- Outputs change only at the WB edge or on reset.

Test Plan:
- Reset: hold reset 1 cycle with start=1 -> out=(200,10), busy=0, done=0, no transaction started.
- Free fall, defaults:
  - verlet, pin_en=0 -> done exactly 2 cycles after start, out=(200,11).
  - Second verlet -> (200,13).
  - Third -> (200,16).
- Pin:
  - pin_en=1, fix=(300,50), cmd 01 -> out=(300,50).
  - Then verlet with pin_en=1 -> stays (300,50).
  - Then verlet with pin_en=0 -> (300,51).
- Mouse:
  - From reset, mouse=(205,15), mouse_down=1, cmd 10 -> out=(205,15).
  - mouse=(220,15) -> unchanged (dx=15>8).
  - mouse_down=0 -> unchanged.
- Clamp with Y_MAX=12:
  - verlet x3 from reset -> y = 11, 12, 12 (velocity killed), x stays 200.
  - DAMP_SHIFT=1 instance from y=10, steps -> y = 11, 12, 13 (v=1 halved to 0, +g).
- Handshake and abort:
  - start pulsed during EXEC -> ignored, single done.
  - reset asserted in EXEC -> no done, out=(200,10).
  - cmd 11 -> done pulses, out unchanged.
